adder_arbiter: RTL
==================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_i  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req0_i  input  1  requester 0 operation request.
REQ-005 The block SHALL have port a0_i  input  WIDTH  requester 0 operand A.
REQ-006 The block SHALL have port b0_i  input  WIDTH  requester 0 operand B.
REQ-007 The block SHALL have port ack0_o  output  1  one-cycle done pulse to requester 0.
REQ-008 The block SHALL have port res0_o  output  WIDTH  last result for requester 0.
REQ-009 The block SHALL have ports req1_i, a1_i, b1_i, ack1_o, res1_o with identical directions, widths and meaning for requester 1.
REQ-010 The block SHALL have port add_a_o  output  WIDTH  operand A driven to the shared combinational adder.
REQ-011 The block SHALL have port add_b_o  output  WIDTH  operand B driven to the shared combinational adder.
REQ-012 The block SHALL have port add_out_i  input  WIDTH  sum returned by the shared adder (combinational, same cycle).
REQ-013 The block SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, DONE.
REQ-015 In IDLE with no request, the FSM SHALL remain in IDLE.
REQ-016 In IDLE with any request high, the FSM SHALL grant one requester, latch its operands into internal registers op_a/op_b, record grant id, and go to CALC.
REQ-017 Arbitration SHALL be round-robin: single request wins; both requesting -> grant the requester not granted last; last-grant pointer updates on every grant.
REQ-018 add_a_o/add_b_o SHALL be driven directly from op_a/op_b at all times (hold last values in IDLE).
REQ-019 In CALC the block SHALL capture add_out_i into the granted requester's result register and go to DONE.
REQ-020 In DONE the block SHALL assert ack of the granted requester for exactly that one cycle and return to IDLE; no arbitration occurs in CALC or DONE.
REQ-021 Latency SHALL be fixed: request sampled at edge N -> result valid and ack high in cycle after edge N+2; minimum period per operation 3 cycles.
REQ-022 ackX_o and resX_o updates SHALL occur only for the granted requester; the other requester's result SHALL be unchanged.
REQ-023 resX_o SHALL hold its value until the next completed operation for that requester.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; carry out is discarded (0xFFFF+0x0001 -> 0x0000).
REQ-025 Operand changes or request deassertion after grant SHALL NOT affect the operation in flight; it completes and acks normally.
REQ-026 A request still high in the cycle after its ack SHALL be treated as a new request.
REQ-027 Simultaneous new request and ack cycle SHALL be resolved by re-arbitration only once back in IDLE.

Reset
REQ-028 rst_i low SHALL immediately force state IDLE, op_a=0, op_b=0, res0_o=0, res1_o=0, ack0_o=0, ack1_o=0, busy_o=0, last-grant pointer = requester 1 (so requester 0 wins the first tie).
REQ-029 Reset asserted mid-operation SHALL abort it with no ack and no result update.

Verification
REQ-030 Reset: drive rst_i low with reqs high -> all outputs 0, busy_o 0; release -> requester 0 granted first.
REQ-031 Single op: req0 a0=10 b0=10 -> busy_o high 2 cycles, ack0_o one-cycle pulse 2 edges after grant, res0_o=20, res1_o stays 0.
REQ-032 Tie: req0 (1,2) and req1 (3,4) held together after reset -> ack0 with res0_o=3, then 3 cycles later ack1 with res1_o=7, then alternation continues.
REQ-033 Wrap: req1 a1=0xFFFF b1=0x0002 -> res1_o=0x0001, no other flag.
REQ-034 Mid-op reset: assert rst_i in CALC -> no ack pulse, res registers 0, state IDLE.
REQ-035 Hold stability: change a0_i/b0_i to 0 the cycle after grant of (5,6) -> res0_o=11.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester front end for one shared combinational adder.
// Round-robin grant, operands latched at grant, registered ack pulse.
module adder_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] b0_i,
  output logic             ack0_o,
  output logic [WIDTH-1:0] res0_o,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] a1_i,
  input  logic [WIDTH-1:0] b1_i,
  output logic             ack1_o,
  output logic [WIDTH-1:0] res1_o,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  input  logic [WIDTH-1:0] add_out_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             sel1;

  // Requester 1 wins if alone, or on a tie when 0 was served last.
  assign sel1 = req1_i & (~req0_i | ~last_q);

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_i | req1_i) begin
          gnt_d   = sel1;
          last_d  = sel1;
          op_a_d  = sel1 ? a1_i : a0_i;
          op_b_d  = sel1 ? b1_i : b0_i;
          state_d = CALC;
        end
      end
      CALC: begin
        if (gnt_q) res1_d = add_out_i;
        else       res0_d = add_out_i;
        state_d = DONE;
      end
      DONE: begin
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  assign add_a_o = op_a_q;
  assign add_b_o = op_b_q;
  assign res0_o  = res0_q;
  assign res1_o  = res1_q;
  assign ack0_o  = ack0_q;
  assign ack1_o  = ack1_q;
  assign busy_o  = (state_q != IDLE);

endmodule
